// File: rtl/openmips_bus_pkg.sv
// rtl/openmips_bus_pkg.sv - shared bus-master FSM encodings and enable constants
// Purpose: state encodings and active levels shared by every OpenMIPS bus master.
// Contents:
//   WB_IDLE / WB_BUSY / WB_WAIT_STALL  2-bit FSM state codes
//   RstEnable, ChipEnable, WriteEnable active levels of rst, ce and we
//   wb_state_t                         typedef for the 2-bit state code
package openmips_bus_pkg;

    typedef logic [1:0] wb_state_t;

    localparam logic [1:0] WB_IDLE       = 2'd0;
    localparam logic [1:0] WB_BUSY       = 2'd1;
    localparam logic [1:0] WB_WAIT_STALL = 2'd2;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

endpackage

// File: rtl/cpu_wishbone_mst_if_if.sv
// rtl/cpu_wishbone_mst_if_if.sv - classic single-beat Wishbone bus bundle
// Purpose: groups the Wishbone master/slave signals of one core memory port.
// Signals (named from the master's point of view):
//   wishbone_cyc_o, wishbone_stb_o, wishbone_we_o  cycle, strobe, write enable
//   wishbone_addr_o, wishbone_data_o, wishbone_sel_o address, write data, byte select
//   wishbone_data_i, wishbone_ack_i                 read data, acknowledge
// Modports: master (drives request, samples response), slave (the reverse).
interface cpu_wishbone_mst_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) ();

    logic                  wishbone_cyc_o;
    logic                  wishbone_stb_o;
    logic                  wishbone_we_o;
    logic [ADDR_WIDTH-1:0] wishbone_addr_o;
    logic [DATA_WIDTH-1:0] wishbone_data_o;
    logic [SEL_WIDTH-1:0]  wishbone_sel_o;
    logic [DATA_WIDTH-1:0] wishbone_data_i;
    logic                  wishbone_ack_i;

    modport master (
        output wishbone_cyc_o,
        output wishbone_stb_o,
        output wishbone_we_o,
        output wishbone_addr_o,
        output wishbone_data_o,
        output wishbone_sel_o,
        input  wishbone_data_i,
        input  wishbone_ack_i
    );

    modport slave (
        input  wishbone_cyc_o,
        input  wishbone_stb_o,
        input  wishbone_we_o,
        input  wishbone_addr_o,
        input  wishbone_data_o,
        input  wishbone_sel_o,
        output wishbone_data_i,
        output wishbone_ack_i
    );

endinterface

// File: rtl/wb_mst_timeout_cnt.sv
// rtl/wb_mst_timeout_cnt.sv - bus-cycle watchdog counter
// Purpose: counts cycles while enabled and flags the last allowed cycle.
// Ports:
//   clk, rst   clock, async active-high reset
//   i_clear    synchronous clear (wins over enable)
//   i_enable   count this cycle
//   o_expire   comb, high in the cycle the count sits at TIMEOUT_CYCLES-1
module wb_mst_timeout_cnt
    import openmips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expire  = i_enable & ~i_clear & w_at_last;

    // Saturates at LAST so a caller that keeps enable high cannot wrap around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_wishbone_mst_if.sv
// rtl/cpu_wishbone_mst_if.sv - OpenMIPS core port to single-beat Wishbone master
// Purpose: turns the core's SRAM-style request into one classic Wishbone cycle,
// stalls the pipeline until ack, and holds read data while the pipeline is stalled.
// Optional feature: define WB_MST_TIMEOUT_EN to abort cycles that see no ack
// within TIMEOUT_CYCLES BUSY cycles (bus_err_o pulses); otherwise BUSY waits forever.
// Ports:
//   clk, rst                    clock, async active-high reset
//   cpu_ce_i, cpu_we_i          request valid, 1=write
//   cpu_addr_i, cpu_data_i      request address, write data
//   cpu_sel_i                   byte enables
//   cpu_data_o                  comb read data to core
//   stall_i, flush_i            pipeline stall / flush from ctrl
//   stallreq_o                  comb stall request to ctrl
//   bus_err_o                   registered 1-cycle timeout pulse
//   wb                          Wishbone master modport
module cpu_wishbone_mst_if
    import openmips_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_data_i,
    input  logic [SEL_WIDTH-1:0]  cpu_sel_i,
    output logic [DATA_WIDTH-1:0] cpu_data_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  bus_err_o,
    cpu_wishbone_mst_if_if.master wb
);

    wb_state_t             r_state;
    wb_state_t             w_next;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [DATA_WIDTH-1:0] r_rd_buf;
    logic                  r_bus_err;

    logic w_busy;
    logic w_start;
    logic w_ack_ok;
    logic w_expire;
    logic w_timeout;
    logic w_drop;
    logic w_is_read;

    assign w_busy    = (r_state == WB_BUSY);
    assign w_is_read = (r_we != WriteEnable);
    assign w_start   = (r_state == WB_IDLE) & (cpu_ce_i == ChipEnable) & ~flush_i;
    assign w_ack_ok  = w_busy & wb.wishbone_ack_i & ~flush_i;
    // Ack and flush both take precedence over an expiring watchdog.
    assign w_timeout = w_busy & w_expire & ~wb.wishbone_ack_i & ~flush_i;
    assign w_drop    = w_busy & (flush_i | wb.wishbone_ack_i | w_expire);

`ifdef WB_MST_TIMEOUT_EN
    wb_mst_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (~w_busy),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_expire             = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            WB_IDLE: begin
                if (w_start) w_next = WB_BUSY;
            end
            WB_BUSY: begin
                if (flush_i || w_timeout) w_next = WB_IDLE;
                else if (w_ack_ok)        w_next = stall_i ? WB_WAIT_STALL : WB_IDLE;
            end
            WB_WAIT_STALL: begin
                if (flush_i || !stall_i) w_next = WB_IDLE;
            end
            default: w_next = WB_IDLE;
        endcase
    end

    // The request is released in the ack cycle itself so the pipeline advances
    // without waiting for the registered bus outputs to fall.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (r_state)
            WB_IDLE: begin
                stallreq_o = w_start;
            end
            WB_BUSY: begin
                stallreq_o = ~flush_i & ~wb.wishbone_ack_i & ~w_expire;
                if (w_ack_ok && w_is_read) cpu_data_o = wb.wishbone_data_i;
            end
            WB_WAIT_STALL: begin
                cpu_data_o = r_rd_buf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_state   <= WB_IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_rd_buf  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_we    <= cpu_we_i;
                r_addr  <= cpu_addr_i;
                r_wdata <= cpu_data_i;
                r_sel   <= cpu_sel_i;
            end else if (w_drop) begin
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_we    <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
                r_sel   <= '0;
            end
            if (w_ack_ok && w_is_read) r_rd_buf <= wb.wishbone_data_i;
        end
    end

    assign wb.wishbone_cyc_o  = r_cyc;
    assign wb.wishbone_stb_o  = r_stb;
    assign wb.wishbone_we_o   = r_we;
    assign wb.wishbone_addr_o = r_addr;
    assign wb.wishbone_data_o = r_wdata;
    assign wb.wishbone_sel_o  = r_sel;
    assign bus_err_o          = r_bus_err;

endmodule
